// File: rtl/instr_fetch.sv
// Instruction pointer and fetch stage: holds the program counter, issues reads to the
// synchronous instruction memory and presents the fetched word and opcode to the controller.
module instr_fetch #(
    parameter int unsigned INSTR_WIDTH      = 128,
    parameter int unsigned ADDR_WIDTH       = 8,
    parameter int unsigned MEM_READ_LATENCY = 2,
    parameter int unsigned JUMP_ADDR_LSB    = 0,
    parameter logic [7:0]  STALL_OPCODE     = 8'hF0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_ptr_en,
    input  logic [1:0]             instr_ptr_load_en,
    input  logic                   alu_cond,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_rd_en,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [7:0]             opcode,
    output logic                   instr_valid,
    output logic [ADDR_WIDTH-1:0]  instr_ptr,
    output logic                   fetch_err
);

    localparam int unsigned          CNT_WIDTH = 3;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MEM_READ_LATENCY);
    localparam logic [1:0]           LD_JUMP   = 2'd1;
    localparam logic [1:0]           LD_COND   = 2'd2;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic [ADDR_WIDTH-1:0]  ptr_nxt;
    logic [ADDR_WIDTH-1:0]  ptr_sel;
    logic [ADDR_WIDTH-1:0]  ptr_inc;
    logic [ADDR_WIDTH-1:0]  jump_target;
    logic [INSTR_WIDTH-1:0] instr_nxt;
    logic                   valid_nxt;
    logic                   err_nxt;

    // State and datapath registers; reset aborts any read in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_FETCH;
            cnt         <= '0;
            instr_ptr   <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            instr_ptr   <= ptr_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            fetch_err   <= err_nxt;
        end
    end

    // Pointer candidate chosen by the load-select code; reserved code increments
    always_comb begin
        ptr_inc     = instr_ptr + ADDR_WIDTH'(1);
        jump_target = instr[JUMP_ADDR_LSB +: ADDR_WIDTH];
        case (instr_ptr_load_en)
            LD_JUMP: ptr_sel = jump_target;
            LD_COND: ptr_sel = alu_cond ? jump_target : ptr_inc;
            default: ptr_sel = ptr_inc;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = instr_ptr;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        err_nxt   = fetch_err;
        case (state)
            ST_FETCH: begin
                // An advance request while nothing valid is held is dropped but flagged
                if (instr_ptr_en) begin
                    err_nxt = 1'b1;
                end
                if (cnt == CNT_LAST) begin
                    instr_nxt = mem_data;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            ST_HOLD: begin
                if (instr_ptr_en) begin
                    ptr_nxt   = ptr_sel;
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        mem_addr  = instr_ptr;
        mem_rd_en = reset && (state == ST_FETCH) && (cnt == '0);
        opcode    = instr_valid ? instr[INSTR_WIDTH-1 -: 8] : STALL_OPCODE;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: timeline-based reference model, directed scenarios and random traffic.
module tb_instr_fetch;

    localparam int unsigned IW    = 128;
    localparam int unsigned AW    = 8;
    localparam int          LAT   = 2;
    localparam logic [7:0]  STALL = 8'hF0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          instr_ptr_en = 1'b0;
    logic [1:0]    instr_ptr_load_en = 2'd0;
    logic          alu_cond = 1'b0;
    logic [IW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [IW-1:0] instr;
    logic [7:0]    opcode;
    logic          instr_valid;
    logic [AW-1:0] instr_ptr;
    logic          fetch_err;

    int tests = 0;
    int fails = 0;

    instr_fetch #(
        .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .MEM_READ_LATENCY(LAT),
        .JUMP_ADDR_LSB(0), .STALL_OPCODE(STALL)
    ) dut (
        .clk(clk), .reset(reset), .instr_ptr_en(instr_ptr_en),
        .instr_ptr_load_en(instr_ptr_load_en), .alu_cond(alu_cond),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .instr_ptr(instr_ptr), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Synchronous memory with LAT-cycle read latency; junk when no read is due
    logic [IW-1:0] mem [256];
    logic [AW-1:0] pa [LAT];
    logic          pv [LAT];
    logic [IW-1:0] junk;

    always @(posedge clk) begin
        pa[0] <= mem_addr;
        pv[0] <= mem_rd_en;
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pv[i] <= pv[i-1];
        end
        junk <= {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    assign mem_data = (pv[LAT-1] === 1'b1) ? mem[pa[LAT-1]] : junk;

    // Reference model: a fetch issued in cycle s delivers a valid word in cycle s+LAT+1
    int            cyc = 0;
    int            m_start = 0;
    logic [AW-1:0] m_ptr = '0;
    logic [IW-1:0] m_held = '0;
    logic          m_err = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ptr   = '0;
            m_held  = '0;
            m_err   = 1'b0;
            m_start = cyc;
        end else begin
            if (instr_ptr_en) begin
                if (cyc >= m_start + LAT + 1) begin
                    case (instr_ptr_load_en)
                        2'd1:    m_ptr = m_held[AW-1:0];
                        2'd2:    m_ptr = alu_cond ? m_held[AW-1:0] : AW'(m_ptr + 1);
                        default: m_ptr = AW'(m_ptr + 1);
                    endcase
                    m_start = cyc + 1;
                end else begin
                    m_err = 1'b1;
                end
            end
            cyc++;
            if (cyc == m_start + LAT + 1) m_held = mem[m_ptr];
        end
    end

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_valid;
        logic exp_rd;
        exp_valid = reset && (cyc >= m_start + LAT + 1);
        exp_rd    = reset && (cyc == m_start);
        chk("instr_valid", IW'(instr_valid), IW'(exp_valid));
        chk("mem_rd_en",   IW'(mem_rd_en),   IW'(exp_rd));
        chk("instr_ptr",   IW'(instr_ptr),   IW'(m_ptr));
        chk("mem_addr",    IW'(mem_addr),    IW'(m_ptr));
        chk("instr",       instr,            m_held);
        chk("opcode",      IW'(opcode),      IW'(exp_valid ? m_held[IW-1 -: 8] : STALL));
        chk("fetch_err",   IW'(fetch_err),   IW'(m_err));
    endtask

    // Drive inputs for one cycle, then check the following cycle at its falling edge
    task automatic step(input logic en, input logic [1:0] le, input logic ac);
        instr_ptr_en      = en;
        instr_ptr_load_en = le;
        alu_cond          = ac;
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 20) begin
            n++;
            step(1'b0, 2'd0, 1'b0);
        end
        chk("valid_timeout", IW'(instr_valid), IW'(1'b1));
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1 compare_all();
    endtask

    task automatic release_reset();
        instr_ptr_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        compare_all();
    endtask

    task automatic accept(input logic [1:0] le, input logic ac, input logic [AW-1:0] exp_ptr);
        int n;
        step(1'b1, le, ac);
        chk("accept_ptr",    IW'(instr_ptr),   IW'(exp_ptr));
        chk("accept_opcode", IW'(opcode),      IW'(STALL));
        chk("accept_rd",     IW'(mem_rd_en),   IW'(1'b1));
        wait_valid(n);
        chk("drop_len",      IW'(n),           IW'(3));
        chk("fetched_word",  instr,            mem[exp_ptr]);
    endtask

    initial begin
        int n;
        for (int a = 0; a < 256; a++) mem[a] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem[3][7:0]     = 8'h40;
        mem[8'h40][7:0] = 8'hFF;
        mem[8'h41][7:0] = 8'h40;

        // Reset state
        @(negedge clk);
        compare_all();
        step(1'b0, 2'd0, 1'b0);
        chk("rst_ptr",   IW'(instr_ptr), IW'(8'h00));
        chk("rst_rd",    IW'(mem_rd_en), IW'(1'b0));
        chk("rst_valid", IW'(instr_valid), IW'(1'b0));

        // First fetch after release targets address 0, valid in cycle 4
        release_reset();
        chk("first_rd",   IW'(mem_rd_en), IW'(1'b1));
        chk("first_addr", IW'(mem_addr),  IW'(8'h00));
        wait_valid(n);
        chk("first_lat",  IW'(n),         IW'(3));
        chk("first_word", instr,          mem[0]);

        // Increments, jumps, conditional jumps, reserved code, wrap
        accept(2'd0, 1'b0, 8'h01);
        accept(2'd0, 1'b0, 8'h02);
        accept(2'd0, 1'b0, 8'h03);
        accept(2'd1, 1'b0, 8'h40);
        accept(2'd2, 1'b0, 8'h41);
        accept(2'd2, 1'b1, 8'h40);
        accept(2'd3, 1'b1, 8'h41);
        accept(2'd2, 1'b1, 8'h40);
        accept(2'd1, 1'b0, 8'hFF);
        accept(2'd0, 1'b0, 8'h00);

        // Advance request during FETCH is ignored but flagged
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd1, 1'b1);
        chk("err_set",   IW'(fetch_err), IW'(1'b1));
        chk("err_ptr",   IW'(instr_ptr), IW'(8'h01));
        wait_valid(n);
        chk("err_lat",   IW'(n),         IW'(2));
        chk("err_word",  instr,          mem[1]);
        step(1'b0, 2'd0, 1'b0);
        chk("err_stick", IW'(fetch_err), IW'(1'b1));

        // Reset mid-fetch with a jump pending
        step(1'b1, 2'd1, 1'b0);
        instr_ptr_en = 1'b0;
        assert_reset();
        chk("mid_ptr",    IW'(instr_ptr),   IW'(8'h00));
        chk("mid_valid",  IW'(instr_valid), IW'(1'b0));
        chk("mid_err",    IW'(fetch_err),   IW'(1'b0));
        chk("mid_rd",     IW'(mem_rd_en),   IW'(1'b0));
        chk("mid_instr",  instr,            '0);
        chk("mid_opcode", IW'(opcode),      IW'(STALL));
        step(1'b0, 2'd0, 1'b0);
        release_reset();
        chk("rel_rd",   IW'(mem_rd_en), IW'(1'b1));
        chk("rel_addr", IW'(mem_addr),  IW'(8'h00));
        wait_valid(n);
        chk("rel_lat",  IW'(n),         IW'(3));
        chk("rel_word", instr,          mem[0]);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                assert_reset();
                step(1'b0, 2'd0, 1'b0);
                step(1'b0, 2'd0, 1'b0);
                release_reset();
            end else begin
                step(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction pointer and fetch stage that feeds the per-core controller. It holds the program counter and issues reads to the synchronous instruction memory. It presents the fetched instruction word, and its opcode, to the controller. It advances or jumps the pointer when the controller asserts `instr_ptr_en` with a load-select code.

## Interface
- `INSTR_WIDTH`, 128: instruction word width; opcode is `instr[INSTR_WIDTH-1 -: 8]`.
- `ADDR_WIDTH`, 8: instruction memory address width.
- `MEM_READ_LATENCY`, 2: cycles from `mem_rd_en` to valid `mem_data`; legal range 1..7.
- `JUMP_ADDR_LSB`, 0: LSB of the jump-target field inside the held instruction.
- `STALL_OPCODE`, 8'hF0: opcode presented while no valid instruction is held; its class nibble decodes to no controller action.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `instr_ptr_en`  in  1  advance pointer this cycle (from controller).
- `instr_ptr_load_en`  in  2  0 = increment, 1 = load jump target, 2 = load target if `alu_cond`, else increment, 3 = reserved, treated as 0.
- `alu_cond`  in  1  ALU compare result bit, sampled with `instr_ptr_en`.
- `mem_data`  in  INSTR_WIDTH  read data from instruction memory.
- `mem_addr`  out  ADDR_WIDTH  read address; always equals `instr_ptr`.
- `mem_rd_en`  out  1  single-cycle read strobe.
- `instr`  out  INSTR_WIDTH  held instruction word.
- `opcode`  out  8  `instr[top 8]` when `instr_valid`, else `STALL_OPCODE`.
- `instr_valid`  out  1  `instr` corresponds to `instr_ptr`.
- `instr_ptr`  out  ADDR_WIDTH  current program counter.
- `fetch_err`  out  1  sticky; set when `instr_ptr_en` arrives while `instr_valid` = 0.

## Operation
- States:
  - FETCH: read in flight; latency counter `cnt` is 3 bits.
  - HOLD: instruction valid, waiting for the controller.
- Reset asserted, asynchronously: state = FETCH, `cnt` = 0, `instr_ptr` = 0, `instr` = 0, `instr_valid` = 0, `fetch_err` = 0. `mem_rd_en` is forced 0 while reset is low.
- FETCH behaviour:
  - `mem_rd_en` = 1 only when `cnt` = 0 and reset is high.
  - `cnt` increments each cycle.
  - When `cnt` = `MEM_READ_LATENCY`: capture `instr` <= `mem_data`, set `instr_valid` <= 1, `cnt` <= 0, go to HOLD.
- HOLD behaviour:
  - With `instr_ptr_en` = 0, hold everything.
  - With `instr_ptr_en` = 1, compute next pointer, set `instr_valid` <= 0, go to FETCH with `cnt` = 0.
- Next pointer:
  - Increment: `instr_ptr` + 1, modulo 2^ADDR_WIDTH. The maximum address wraps to 0.
  - Load: `instr[JUMP_ADDR_LSB +: ADDR_WIDTH]` of the currently held instruction.
  - Conditional load: as above when `alu_cond` = 1, else increment.
- `instr_ptr_en` in FETCH:
  - Ignored; pointer, counter and fetch are unaffected.
  - Sets `fetch_err` <= 1, which stays set until reset.
- `instr` is not cleared on leaving HOLD; only `instr_valid` and `opcode` change.
- Reset mid-fetch aborts the read. The first read after reset release is always address 0. Late `mem_data` is ignored because `cnt` restarts at 0.

## Timing
- After reset release, the first rising edge begins FETCH with `mem_rd_en` = 1 for address 0. `instr_valid` rises `MEM_READ_LATENCY` + 1 cycles after that first `mem_rd_en` cycle.
- `instr_ptr_en` = 1 in cycle N (HOLD):
  - Cycle N+1: `instr_ptr` holds the new value, `instr_valid` = 0, `opcode` = `STALL_OPCODE`, `mem_rd_en` = 1.
  - Cycle N+2+L (L = `MEM_READ_LATENCY`): `instr_valid` = 1. Default turnaround is 4 cycles.
- `opcode` and `instr_valid` are registered-state derived; there is no combinational path from `mem_data`.
- `instr_ptr_load_en` and `alu_cond` are sampled only on the edge where `instr_ptr_en` is accepted in HOLD.
- Throughput: one instruction per (L + 2) cycles maximum, since the controller can accept in the first HOLD cycle.

## Test plan
- Reset, then release with memory holding word k at address k (L = 2): `mem_rd_en` at cycle 1 with addr 0; `instr_valid` high at cycle 4; `instr` = word 0; `instr_ptr` = 0.
- Three pulses of `instr_ptr_en` with load_en = 0, each in the first HOLD cycle: `instr_ptr` steps 1, 2, 3. Each `instr_valid` drop lasts exactly 3 cycles, with `opcode` = 8'hF0 during the drop.
- Held instruction with target field 8'h40, load_en = 1: `instr_ptr` = 8'h40 next cycle; `instr` = word 0x40 after 3 more cycles. Repeat with load_en = 2: `alu_cond` = 0 gives ptr + 1, `alu_cond` = 1 gives 8'h40. load_en = 3 gives ptr + 1.
- Pointer at 8'hFF, increment: `instr_ptr` = 8'h00; `mem_addr` = 0 with `mem_rd_en` = 1.
- `instr_ptr_en` pulsed during the FETCH cycle after an accept: `fetch_err` = 1 permanently. `instr_ptr` does not change again, and `instr_valid` still rises on schedule.
- Reset asserted mid-FETCH (`cnt` = 1) with a jump pending: all outputs return to reset values asynchronously. After release, a fresh fetch of address 0 occurs; `fetch_err` is cleared.
